alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst_n  input  1  reset, asynchronous, active-low.
REQ-003 req0, req1  input  1 each  operation request from requester 0 / 1.
REQ-004 a0, b0, a1, b1  input  16 each  operands; held stable while the matching req is high until its ack.
REQ-005 sel0, sel1  input  3 each  operation select, encoded per the shared package.
REQ-006 ack0, ack1  output  1 each  one-cycle pulse: request accepted and operands latched.
REQ-007 res0, res1  output  16 each  last completed result for that requester; held until its next completion.
REQ-008 done0, done1  output  1 each  one-cycle pulse: matching res updated, or op rejected.
REQ-009 err  output  1  high with a done pulse when the completed op had an invalid sel.
REQ-010 busy  output  1  high whenever state is not IDLE.
REQ-011 ops_count  output  8  count of completed valid operations.

Function
REQ-012 Op encoding shall be 3'h1 ADD, 3'h2 SUB, 3'h3 AND, 3'h4 OR, 3'h5 XOR; 3'h0, 3'h6 and 3'h7 are invalid.
REQ-013 FSM states shall be IDLE, EXEC, DONE; IDLE->EXEC when any req is high; EXEC->DONE unconditionally; DONE->IDLE unconditionally.
REQ-014 On IDLE->EXEC, the winner's a, b and sel shall be latched, and its ack shall be high for the EXEC cycle only.
REQ-015 In EXEC the alu instance shall be driven from latched operands only; on EXEC->DONE, ALU_Out shall be written to the winner's res.
REQ-016 In DONE the winner's done shall be high for exactly one cycle; the loser's done, ack and res shall be unchanged.
REQ-017 Latency: req high in IDLE at edge k -> ack high cycle k+1, res/done valid cycle k+2, IDLE again cycle k+3; throughput one op per 3 cycles.
REQ-018 Arbitration shall be round-robin on one pointer; requester 0 has priority after reset; the pointer moves to the non-winner on DONE->IDLE.
REQ-019 With only one req high, that requester shall win regardless of the pointer.
REQ-020 Invalid sel shall still be granted and run the full cycle; res shall stay unchanged, err and done shall pulse together, and ops_count shall not increment.
REQ-021 ops_count shall increment on each valid DONE and wrap 8'hFF -> 8'h00.
REQ-022 ALU arithmetic shall be 16-bit modulo; carry and borrow are discarded.
REQ-023 A req still high in IDLE after its completion shall be treated as a new request.
REQ-024 req changes during EXEC or DONE shall be ignored until the next IDLE.

Reset
REQ-025 rst_n low shall force, immediately and independent of clk: state IDLE, pointer 0, all ack/done/err 0, busy 0, res0 = res1 = 16'h0000, ops_count 8'h00, latched operands 0.
REQ-026 Reset asserted during EXEC or DONE shall abort the op with no done pulse and no res update.

Structure
REQ-027 Package alu_pkg shall hold DATA_W=16, SEL_W=3, the op encoding constants and the FSM state typedef.
REQ-028 The existing alu module (ports A, B, ALU_Sel, ALU_Out) shall be the single sub-module, instantiated once.

Verification
REQ-029 Reset then req0 with a0=16'h0AB0, b0=16'h01AC, sel0=ADD -> ack0 at k+1; res0=16'h0C5C with done0 at k+2; ops_count=1.
REQ-030 Same operands with SUB, AND, OR, XOR in turn -> 16'h0904, 16'h00A0, 16'h0BBC, 16'h0B1C; ops_count ends at 5.
REQ-031 req0 and req1 both high continuously after reset -> grants alternate 0,1,0,1; each res matches its own operands; no stray done.
REQ-032 req1 with sel1=3'h7 -> done1 and err high together; res1 unchanged; ops_count unchanged.
REQ-033 rst_n dropped mid-EXEC -> all outputs zero at once; no done; first grant after release goes to requester 0.
REQ-034 256 valid ops -> ops_count wraps to 8'h00; busy low only in IDLE cycles.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared widths, op encoding and FSM state type for alu_arbiter
package alu_pkg;

  localparam int DATA_W = 16;
  localparam int SEL_W  = 3;

  localparam logic [SEL_W-1:0] OP_ADD = 3'h1;
  localparam logic [SEL_W-1:0] OP_SUB = 3'h2;
  localparam logic [SEL_W-1:0] OP_AND = 3'h3;
  localparam logic [SEL_W-1:0] OP_OR  = 3'h4;
  localparam logic [SEL_W-1:0] OP_XOR = 3'h5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Valid ops occupy the contiguous range ADD..XOR.
  function automatic logic op_valid(input logic [SEL_W-1:0] sel);
    return (sel >= OP_ADD) && (sel <= OP_XOR);
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - two-requester ALU request/response bundle
interface alu_arbiter_if;
  import alu_pkg::*;

  logic              req0;
  logic              req1;
  logic [DATA_W-1:0] a0;
  logic [DATA_W-1:0] b0;
  logic [DATA_W-1:0] a1;
  logic [DATA_W-1:0] b1;
  logic [SEL_W-1:0]  sel0;
  logic [SEL_W-1:0]  sel1;
  logic              ack0;
  logic              ack1;
  logic [DATA_W-1:0] res0;
  logic [DATA_W-1:0] res1;
  logic              done0;
  logic              done1;
  logic              err;
  logic              busy;
  logic [7:0]        ops_count;

  modport master (
    output req0, req1, a0, b0, a1, b1, sel0, sel1,
    input  ack0, ack1, res0, res1, done0, done1, err, busy, ops_count
  );

  modport slave (
    input  req0, req1, a0, b0, a1, b1, sel0, sel1,
    output ack0, ack1, res0, res1, done0, done1, err, busy, ops_count
  );

endinterface

// File: rtl/alu.sv
// rtl/alu.sv - combinational 16-bit ALU; invalid selects produce zero
module alu
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic [SEL_W-1:0]  ALU_Sel,
  output logic [DATA_W-1:0] ALU_Out
);

  always_comb begin
    ALU_Out = '0;
    case (ALU_Sel)
      OP_ADD:  ALU_Out = A + B;
      OP_SUB:  ALU_Out = A - B;
      OP_AND:  ALU_Out = A & B;
      OP_OR:   ALU_Out = A | B;
      OP_XOR:  ALU_Out = A ^ B;
      default: ALU_Out = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter sharing one ALU between two requesters
module alu_arbiter
  import alu_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  alu_arbiter_if.slave bus
);

  state_t            state_q, state_d;
  logic              ptr_q, ptr_d;
  logic              winner_q, winner_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic              ack0_q, ack0_d;
  logic              ack1_q, ack1_d;
  logic              done0_q, done0_d;
  logic              done1_q, done1_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] res0_q, res0_d;
  logic [DATA_W-1:0] res1_q, res1_d;
  logic [7:0]        ops_count_q, ops_count_d;
  logic              win;
  logic [DATA_W-1:0] alu_out;

  alu u_alu (
    .A       (a_q),
    .B       (b_q),
    .ALU_Sel (sel_q),
    .ALU_Out (alu_out)
  );

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    winner_d    = winner_q;
    a_d         = a_q;
    b_d         = b_q;
    sel_d       = sel_q;
    ack0_d      = 1'b0;
    ack1_d      = 1'b0;
    done0_d     = 1'b0;
    done1_d     = 1'b0;
    err_d       = 1'b0;
    res0_d      = res0_q;
    res1_d      = res1_q;
    ops_count_d = ops_count_q;

    // A lone requester wins outright; the pointer only breaks ties.
    win = ptr_q;
    if (bus.req0 && !bus.req1) begin
      win = 1'b0;
    end else if (bus.req1 && !bus.req0) begin
      win = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.req0 || bus.req1) begin
          state_d  = ST_EXEC;
          winner_d = win;
          a_d      = win ? bus.a1   : bus.a0;
          b_d      = win ? bus.b1   : bus.b0;
          sel_d    = win ? bus.sel1 : bus.sel0;
          ack0_d   = !win;
          ack1_d   = win;
        end
      end
      ST_EXEC: begin
        state_d = ST_DONE;
        done0_d = !winner_q;
        done1_d = winner_q;
        if (op_valid(sel_q)) begin
          ops_count_d = ops_count_q + 8'd1;
          if (winner_q) begin
            res1_d = alu_out;
          end else begin
            res0_d = alu_out;
          end
        end else begin
          err_d = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        ptr_d   = !winner_q;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= 1'b0;
      winner_q    <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      sel_q       <= '0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      done0_q     <= 1'b0;
      done1_q     <= 1'b0;
      err_q       <= 1'b0;
      res0_q      <= '0;
      res1_q      <= '0;
      ops_count_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      winner_q    <= winner_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sel_q       <= sel_d;
      ack0_q      <= ack0_d;
      ack1_q      <= ack1_d;
      done0_q     <= done0_d;
      done1_q     <= done1_d;
      err_q       <= err_d;
      res0_q      <= res0_d;
      res1_q      <= res1_d;
      ops_count_q <= ops_count_d;
    end
  end

  assign bus.ack0      = ack0_q;
  assign bus.ack1      = ack1_q;
  assign bus.done0     = done0_q;
  assign bus.done1     = done1_q;
  assign bus.err       = err_q;
  assign bus.res0      = res0_q;
  assign bus.res1      = res1_q;
  assign bus.ops_count = ops_count_q;
  assign bus.busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - self-checking bench for alu_arbiter
module tb_alu_arbiter;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_arbiter_if bus ();

  alu_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int          checks   = 0;
  int          failures = 0;
  logic [15:0] exp_res [2];
  int          exp_ops;

  // Behavioural op table; invalid selects leave the old result in place.
  function automatic logic [15:0] ref_op(input logic [2:0] s, input logic [15:0] a,
                                         input logic [15:0] b, input logic [15:0] old);
    case (s)
      3'h1:    return a + b;
      3'h2:    return a - b;
      3'h3:    return a & b;
      3'h4:    return a | b;
      3'h5:    return a ^ b;
      default: return old;
    endcase
  endfunction

  function automatic bit is_valid(input logic [2:0] s);
    return (s >= 3'h1) && (s <= 3'h5);
  endfunction

  task automatic apply_reset();
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.a0 = '0; bus.b0 = '0; bus.sel0 = '0;
    bus.a1 = '0; bus.b1 = '0; bus.sel1 = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_res[0] = '0;
    exp_res[1] = '0;
    exp_ops    = 0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({bus.ack0, bus.ack1, bus.done0, bus.done1, bus.err, bus.busy} !== 6'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got %b expected 000000",
               {bus.ack0, bus.ack1, bus.done0, bus.done1, bus.err, bus.busy});
    end
    checks++;
    if ({bus.res0, bus.res1} !== 32'h0) begin
      failures++;
      $display("FAIL reset_res: got %h expected 00000000", {bus.res0, bus.res1});
    end
    checks++;
    if (bus.ops_count !== 8'h00) begin
      failures++;
      $display("FAIL reset_ops: got %h expected 00", bus.ops_count);
    end
  endtask

  task automatic test_ops();
    logic [15:0] exp_tab [5];
    exp_tab = '{16'h0C5C, 16'h0904, 16'h00A0, 16'h0BBC, 16'h0B1C};
    for (int i = 0; i < 5; i++) begin
      bus.req0 = 1'b1; bus.a0 = 16'h0AB0; bus.b0 = 16'h01AC; bus.sel0 = 3'(i + 1);
      @(negedge clk);
      checks++;
      if ({bus.ack0, bus.ack1, bus.busy} !== 3'b101) begin
        failures++;
        $display("FAIL ops_ack[%0d]: got %b expected 101", i, {bus.ack0, bus.ack1, bus.busy});
      end
      bus.req0 = 1'b0;
      @(negedge clk);
      exp_res[0] = exp_tab[i];
      exp_ops++;
      checks++;
      if ({bus.done0, bus.done1, bus.err} !== 3'b100) begin
        failures++;
        $display("FAIL ops_done[%0d]: got %b expected 100", i, {bus.done0, bus.done1, bus.err});
      end
      checks++;
      if (bus.res0 !== exp_res[0]) begin
        failures++;
        $display("FAIL ops_res[%0d]: got %h expected %h", i, bus.res0, exp_res[0]);
      end
      checks++;
      if (bus.ops_count !== 8'(exp_ops)) begin
        failures++;
        $display("FAIL ops_count[%0d]: got %0d expected %0d", i, bus.ops_count, exp_ops);
      end
      @(negedge clk);
      checks++;
      if ({bus.done0, bus.busy} !== 2'b00) begin
        failures++;
        $display("FAIL ops_idle[%0d]: got %b expected 00", i, {bus.done0, bus.busy});
      end
    end
  endtask

  task automatic test_round_robin();
    int w = 0;
    apply_reset();
    bus.a0 = 16'($urandom); bus.b0 = 16'($urandom); bus.sel0 = 3'($urandom_range(1, 5));
    bus.a1 = 16'($urandom); bus.b1 = 16'($urandom); bus.sel1 = 3'($urandom_range(1, 5));
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({bus.ack0, bus.ack1} !== (w == 1 ? 2'b01 : 2'b10)) begin
        failures++;
        $display("FAIL rr_ack[%0d]: got %b expected winner %0d", i, {bus.ack0, bus.ack1}, w);
      end
      @(negedge clk);
      if (w == 0) exp_res[0] = ref_op(bus.sel0, bus.a0, bus.b0, exp_res[0]);
      else        exp_res[1] = ref_op(bus.sel1, bus.a1, bus.b1, exp_res[1]);
      exp_ops++;
      checks++;
      if ({bus.done0, bus.done1} !== (w == 1 ? 2'b01 : 2'b10)) begin
        failures++;
        $display("FAIL rr_done[%0d]: got %b expected winner %0d", i, {bus.done0, bus.done1}, w);
      end
      checks++;
      if ({bus.res0, bus.res1} !== {exp_res[0], exp_res[1]}) begin
        failures++;
        $display("FAIL rr_res[%0d]: got %h/%h expected %h/%h", i, bus.res0, bus.res1,
                 exp_res[0], exp_res[1]);
      end
      @(negedge clk);
      checks++;
      if ({bus.done0, bus.done1, bus.ack0, bus.ack1} !== 4'b0) begin
        failures++;
        $display("FAIL rr_idle[%0d]: got %b expected 0000", i,
                 {bus.done0, bus.done1, bus.ack0, bus.ack1});
      end
      w = 1 - w;
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
  endtask

  task automatic test_invalid();
    bus.req1 = 1'b1; bus.a1 = 16'($urandom); bus.b1 = 16'($urandom); bus.sel1 = 3'h7;
    @(negedge clk);
    checks++;
    if ({bus.ack0, bus.ack1} !== 2'b01) begin
      failures++;
      $display("FAIL inv_ack: got %b expected 01", {bus.ack0, bus.ack1});
    end
    bus.req1 = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.done0, bus.done1, bus.err} !== 3'b011) begin
      failures++;
      $display("FAIL inv_done_err: got %b expected 011", {bus.done0, bus.done1, bus.err});
    end
    checks++;
    if (bus.res1 !== exp_res[1]) begin
      failures++;
      $display("FAIL inv_res1: got %h expected %h", bus.res1, exp_res[1]);
    end
    checks++;
    if (bus.ops_count !== 8'(exp_ops)) begin
      failures++;
      $display("FAIL inv_ops: got %0d expected %0d", bus.ops_count, exp_ops);
    end
    @(negedge clk);
    checks++;
    if (bus.err !== 1'b0) begin
      failures++;
      $display("FAIL inv_err_clear: got %b expected 0", bus.err);
    end
  endtask

  task automatic test_reset_mid_exec();
    bus.req0 = 1'b1; bus.a0 = 16'($urandom); bus.b0 = 16'($urandom); bus.sel0 = 3'h1;
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.ack0, bus.ack1, bus.done0, bus.done1, bus.err, bus.busy} !== 6'b0) begin
      failures++;
      $display("FAIL rst_ctrl: got %b expected 000000",
               {bus.ack0, bus.ack1, bus.done0, bus.done1, bus.err, bus.busy});
    end
    checks++;
    if ({bus.res0, bus.res1, bus.ops_count} !== 40'h0) begin
      failures++;
      $display("FAIL rst_state: got %h expected 0", {bus.res0, bus.res1, bus.ops_count});
    end
    bus.req0 = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.done0, bus.res0} !== 17'h0) begin
      failures++;
      $display("FAIL rst_no_done: got %h expected 0", {bus.done0, bus.res0});
    end
    rst_n = 1'b1;
    exp_res[0] = '0; exp_res[1] = '0; exp_ops = 0;
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    bus.a1 = 16'($urandom); bus.b1 = 16'($urandom); bus.sel1 = 3'h2;
    @(negedge clk);
    checks++;
    if ({bus.ack0, bus.ack1} !== 2'b10) begin
      failures++;
      $display("FAIL rst_first_grant: got %b expected 10", {bus.ack0, bus.ack1});
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    @(negedge clk);
    exp_res[0] = ref_op(bus.sel0, bus.a0, bus.b0, exp_res[0]);
    exp_ops++;
    checks++;
    if (bus.res0 !== exp_res[0]) begin
      failures++;
      $display("FAIL rst_after_res: got %h expected %h", bus.res0, exp_res[0]);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    int          stage  = 0;
    int          w      = 0;
    int          prefer = 0;
    logic [2:0]  ws;
    logic [15:0] wa, wb;
    logic [1:0]  e_ack  = 2'b00;
    logic [1:0]  e_done = 2'b00;
    logic        e_err  = 1'b0;
    logic        old0, old1, nr0, nr1;
    apply_reset();
    for (int c = 0; c < 300; c++) begin
      checks++;
      if ({bus.ack1, bus.ack0} !== e_ack) begin
        failures++;
        $display("FAIL rnd_ack[%0d]: got %b expected %b", c, {bus.ack1, bus.ack0}, e_ack);
      end
      checks++;
      if ({bus.done1, bus.done0, bus.err} !== {e_done, e_err}) begin
        failures++;
        $display("FAIL rnd_done[%0d]: got %b expected %b", c,
                 {bus.done1, bus.done0, bus.err}, {e_done, e_err});
      end
      checks++;
      if (bus.busy !== (stage != 0)) begin
        failures++;
        $display("FAIL rnd_busy[%0d]: got %b expected %b", c, bus.busy, stage != 0);
      end
      checks++;
      if ({bus.res0, bus.res1, bus.ops_count} !== {exp_res[0], exp_res[1], 8'(exp_ops)}) begin
        failures++;
        $display("FAIL rnd_res[%0d]: got %h/%h/%0d expected %h/%h/%0d", c, bus.res0, bus.res1,
                 bus.ops_count, exp_res[0], exp_res[1], 8'(exp_ops));
      end
      // Operands may only change once a pending request has been acknowledged.
      old0 = bus.req0; old1 = bus.req1;
      nr0  = ($urandom_range(0, 2) != 0);
      nr1  = ($urandom_range(0, 2) != 0);
      if (nr0 && !(old0 && !e_ack[0])) begin
        bus.a0 = 16'($urandom); bus.b0 = 16'($urandom); bus.sel0 = 3'($urandom);
      end
      if (nr1 && !(old1 && !e_ack[1])) begin
        bus.a1 = 16'($urandom); bus.b1 = 16'($urandom); bus.sel1 = 3'($urandom);
      end
      bus.req0 = nr0; bus.req1 = nr1;
      e_ack = 2'b00; e_done = 2'b00; e_err = 1'b0;
      if (stage == 0) begin
        if (nr0 || nr1) begin
          w  = (nr0 && nr1) ? prefer : (nr1 ? 1 : 0);
          ws = w ? bus.sel1 : bus.sel0;
          wa = w ? bus.a1   : bus.a0;
          wb = w ? bus.b1   : bus.b0;
          e_ack[w] = 1'b1;
          stage = 1;
        end
      end else if (stage == 1) begin
        e_done[w] = 1'b1;
        if (is_valid(ws)) begin
          exp_res[w] = ref_op(ws, wa, wb, exp_res[w]);
          exp_ops++;
        end else begin
          e_err = 1'b1;
        end
        stage = 2;
      end else begin
        prefer = 1 - w;
        stage  = 0;
      end
      @(negedge clk);
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_wrap();
    apply_reset();
    for (int i = 0; i < 256; i++) begin
      bus.req0 = 1'b1; bus.a0 = 16'($urandom); bus.b0 = 16'($urandom);
      bus.sel0 = 3'($urandom_range(1, 5));
      @(negedge clk);
      checks++;
      if ({bus.busy, bus.ack0} !== 2'b11) begin
        failures++;
        $display("FAIL wrap_exec[%0d]: got %b expected 11", i, {bus.busy, bus.ack0});
      end
      bus.req0 = 1'b0;
      @(negedge clk);
      exp_res[0] = ref_op(bus.sel0, bus.a0, bus.b0, exp_res[0]);
      exp_ops++;
      checks++;
      if ({bus.busy, bus.res0, bus.ops_count} !== {1'b1, exp_res[0], 8'(exp_ops)}) begin
        failures++;
        $display("FAIL wrap_done[%0d]: got %b/%h/%h expected 1/%h/%h", i, bus.busy, bus.res0,
                 bus.ops_count, exp_res[0], 8'(exp_ops));
      end
      @(negedge clk);
      checks++;
      if (bus.busy !== 1'b0) begin
        failures++;
        $display("FAIL wrap_idle[%0d]: got %b expected 0", i, bus.busy);
      end
    end
    checks++;
    if (bus.ops_count !== 8'h00) begin
      failures++;
      $display("FAIL wrap_final: got %h expected 00", bus.ops_count);
    end
  endtask

  initial begin
    test_reset();
    test_ops();
    test_round_robin();
    test_invalid();
    test_reset_mid_exec();
    test_random();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
